// File: rtl/bcd_seg_scan_pkg.sv
// bcd_seg_scan_pkg: shared seven-segment constants and BCD segment lookup
package bcd_seg_scan_pkg;
  // Segments are {g,f,e,d,c,b,a} and active-low: a 0 bit lights the segment.
  // Anodes are active-low as well (common-anode display): a 0 bit enables the digit.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Codes 10..15 are not BCD and show a dash so a broken counter is visible
  function automatic logic [6:0] seg_lut(input logic [3:0] v);
    case (v)
      4'd0:    seg_lut = SEG_0;
      4'd1:    seg_lut = SEG_1;
      4'd2:    seg_lut = SEG_2;
      4'd3:    seg_lut = SEG_3;
      4'd4:    seg_lut = SEG_4;
      4'd5:    seg_lut = SEG_5;
      4'd6:    seg_lut = SEG_6;
      4'd7:    seg_lut = SEG_7;
      4'd8:    seg_lut = SEG_8;
      4'd9:    seg_lut = SEG_9;
      default: seg_lut = SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/bcd_seg_scan_bcd_to_seg.sv
// bcd_to_seg: combinational BCD code to active-low segment pattern with blanking
module bcd_to_seg
  import bcd_seg_scan_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg
);
  // blank overrides the decoded pattern
  always_comb seg = blank ? SEG_BLANK : seg_lut(code);
endmodule

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: four-digit multiplexed seven-segment driver with frame snapshot
module bcd_seg_scan
  import bcd_seg_scan_pkg::*;
#(
  parameter int SCAN_DIV_W = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);
  localparam logic [SCAN_DIV_W-1:0] DIV_ONE = 1;

  logic [SCAN_DIV_W-1:0] div_cnt;
  logic [1:0]            sel;
  logic [15:0]           shd_bcd;
  logic [3:0]            shd_dp;
  logic                  tick;
  logic [3:0]            dig;
  logic [3:0]            lz;
  logic                  blank;
  logic [6:0]            seg_d;

  // slot boundary and end-of-frame strobe (last slot of digit 3)
  always_comb begin
    tick       = en && (&div_cnt);
    frame_done = tick && (sel == 2'd3);
  end

  // current digit and leading-zero mask; digit0 always shows so a zero reads as 0
  always_comb begin
    dig   = shd_bcd[{sel, 2'b00} +: 4];
    lz[3] = ~|shd_bcd[15:12];
    lz[2] = lz[3] & ~|shd_bcd[11:8];
    lz[1] = lz[2] & ~|shd_bcd[7:4];
    lz[0] = 1'b0;
    blank = blank_lz & lz[sel];
  end

  bcd_to_seg u_dec (
    .code  (dig),
    .blank (blank),
    .seg   (seg_d)
  );

  // prescaler, digit scan, frame snapshot and registered display outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      sel     <= 2'd0;
      shd_bcd <= 16'h0000;
      shd_dp  <= 4'h0;
      an      <= AN_OFF;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
    end else begin
      if (en) div_cnt <= div_cnt + DIV_ONE;
      if (tick) sel <= sel + 2'd1;
      if (frame_done) begin
        shd_bcd <= bcd_in;
        shd_dp  <= dp_in;
      end
      an  <= en ? ~(4'b0001 << sel) : AN_OFF;
      seg <= en ? seg_d : SEG_BLANK;
      dp  <= en ? ~shd_dp[sel] : 1'b1;
    end
  end
endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Four-digit multiplexed seven-segment driver. It consumes packed BCD digits from the BCD counter chain and drives the board's common-anode display. Each digit is strobed in turn at a programmable scan rate. Digit values are snapshotted once per frame so the display does not tear, and the block provides optional leading-zero blanking and an invalid-code indicator.

## Interface
- SCAN_DIV_W, 17, prescaler width; one digit slot = 2^SCAN_DIV_W clk cycles (1.31 ms at 100 MHz)
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- en  in  1  scan enable; low = display dark, scan frozen
- bcd_in  in  16  packed digits; [3:0] = digit0 (rightmost) … [15:12] = digit3
- dp_in  in  4  decimal point request per digit, active-high, bit i = digit i
- blank_lz  in  1  leading-zero blanking enable
- an  out  4  anode select, active-low, bit i = digit i
- seg  out  7  segments, active-low, seg[0]=a … seg[6]=g
- dp  out  1  decimal point, active-low
- frame_done  out  1  one-cycle pulse per completed frame

## Operation
- Prescaler div_cnt (SCAN_DIV_W bits) increments each clk while en=1 and wraps naturally.
  - tick = en && div_cnt == all-ones.
- Digit index sel (2 bits) advances on tick: 0→1→2→3→0.
- Snapshot registers shd_bcd/shd_dp load bcd_in/dp_in on the tick where sel==3 (the 3→0 wrap).
  - frame_done pulses in that same cycle.
  - Inputs are otherwise ignored.
- Decode of digit value v = shd_bcd[4*sel+3:4*sel]:
  - 0..9 → 40,79,24,30,19,12,02,78,00,10 (hex, {g..a}).
  - 10..15 → dash 3F.
- Leading-zero blanking (blank_lz=1):
  - digit k∈{3,2,1} is blanked (seg=7F) when shd digits k..3 are all zero.
  - digit0 is never blanked.
  - Invalid codes count as non-zero.
- dp = ~shd_dp[sel], regardless of blanking.
- an = ~(4'b1 << sel) when en=1, else 4'hF; seg=7F and dp=1 while en=0.
- en=0: div_cnt, sel and snapshot hold. Re-enabling resumes the same digit with its remaining count.

## Timing
- an/seg/dp are registered from sel and the snapshot registers: outputs lag the sel change by 1 clk.
- en falling: outputs dark on the next edge. en rising: driven on the next edge.
- Reset values: div_cnt=0, sel=0, shd_bcd=0, shd_dp=0, an=4'hF, seg=7'h7F, dp=1, frame_done=0.
- Reset is asynchronous: all outputs go to reset values immediately, including mid-frame. The first snapshot is taken on the first 3→0 wrap after reset release; until then the display shows 0000 (or blank,blank,blank,0).
- A bcd_in change in the same cycle as the snapshot tick is captured.
- First valid frame after reset: sel 0..3 each for 2^SCAN_DIV_W cycles, then snapshot.

## Structure
- Shared include/package seg_defs holds:
  - the segment constants SEG_0..SEG_9, SEG_DASH (3F) and SEG_BLANK (7F);
  - the active-low polarity notes.
- Sub-module bcd_to_seg is combinational: 4-bit code + blank → 7-bit seg. It is reused by other display blocks.
- Top level holds the prescaler, sel, snapshot, the blanking logic and the output registers.

## Test plan
All scenarios run with SCAN_DIV_W=2 (4 clk per digit).
- Reset: hold rst=0 with arbitrary inputs → an=F, seg=7F, dp=1, frame_done=0. Release with en=0 → outputs stay dark, sel stays 0.
- Basic scan: bcd_in=16'h1234, blank_lz=0, en=1. After the first frame_done:
  - an cycles E,D,B,7, each for 4 clk;
  - seg is 19, 30, 24, 79 respectively;
  - frame_done pulses every 16 clk.
- Blanking, bcd_in=16'h0090, blank_lz=1 → digit0 40, digit1 10, digit2/3 7F.
- Blanking, bcd_in=0000, blank_lz=1 → digit0 40, all others 7F.
- Blanking, bcd_in=0000, blank_lz=0 → all digits 40.
- Invalid code and dp: bcd_in=16'h00A0, blank_lz=1, dp_in=4'b0010 → digit1 seg=3F with dp=0; digits 2/3 blank; digit0 40 with dp=1.
- Snapshot/pause: change bcd_in from 16'h5555 to 16'h6666 mid-frame → display stays 12 until after the next frame_done, then shows 02. Drop en for 10 clk mid-slot → an=F next clk, sel/div_cnt unchanged, same digit resumes. Assert rst mid-frame → immediate reset values.
